// File: rtl/fifo_pkg.sv
// Shared defaults and parameter legality checks for the synchronous FIFO.
package fifo_pkg;

  localparam int DEFAULT_DEPTH      = 16;
  localparam int DEFAULT_DATA_WIDTH = 8;

  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_thresh_ok(input int depth, input int af);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit ae_thresh_ok(input int depth, input int ae);
    return (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with level-decoded flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wrEn_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic                       rdEn_i,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       rdValid_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflw_o,
  output logic                       underflw_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int LVL_W     = PTR_WIDTH + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0] AE_LVL   = LVL_W'(AE_THRESH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (!af_thresh_ok(DEPTH, AF_THRESH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if (!ae_thresh_ok(DEPTH, AE_THRESH)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  wr_acc, rd_acc;

  // A full FIFO still takes a write when a pop frees a slot on the same edge.
  assign rd_acc = rdEn_i & ~empty_o;
  assign wr_acc = wrEn_i & (~full_o | rd_acc);

  assign full_o         = (level == FULL_LVL);
  assign empty_o        = (level == '0);
  assign almost_full_o  = (level >= AF_LVL);
  assign almost_empty_o = (level <= AE_LVL);
  assign level_o        = level;

  fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wdata_i),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflw_o  <= 1'b0;
      underflw_o <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      overflw_o  <= wrEn_i & ~wr_acc;
      underflw_o <= rdEn_i & ~rd_acc;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata_o   = empty_o ? '0 : ram_rdata;
  assign rdValid_o = ~empty_o;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_o   <= '0;
      rdValid_o <= 1'b0;
    end else begin
      rdValid_o <= rd_acc;
      if (rd_acc) rdata_o <= ram_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DEPTH=16, DATA_WIDTH=8, AF=12, AE=2).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wrEn_i = 1'b0;
  logic       rdEn_i = 1'b0;
  logic [7:0] wdata_i = '0;
  logic [7:0] rdata_o;
  logic       rdValid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic [4:0] level_o;
  logic       overflw_o, underflw_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DEPTH(16), .DATA_WIDTH(8), .AF_THRESH(12), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wrEn_i(wrEn_i), .wdata_i(wdata_i), .rdEn_i(rdEn_i),
    .rdata_o(rdata_o), .rdValid_o(rdValid_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o), .level_o(level_o),
    .overflw_o(overflw_o), .underflw_o(underflw_o)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wrEn_i = 1'b0;
    rdEn_i = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // One clock of traffic; returns the word popped by this cycle's read.
  task automatic xfer(input logic wr, input logic [7:0] wd, input logic rd,
                      output logic [7:0] rd_data, output logic rd_valid);
`ifdef SYNC_FIFO_FWFT_EN
    rd_data  = rdata_o;
    rd_valid = rdValid_o;
`endif
    wrEn_i  = wr;
    wdata_i = wd;
    rdEn_i  = rd;
    tick();
    wrEn_i = 1'b0;
    rdEn_i = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    rd_data  = rdata_o;
    rd_valid = rdValid_o;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (level_o !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_o); end
    checks++; if (empty_o !== 1'b1 || almost_empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b/%b exp=1/1", empty_o, almost_empty_o); end
    checks++; if (full_o !== 1'b0 || almost_full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%b/%b exp=0/0", full_o, almost_full_o); end
    checks++; if (rdata_o !== 8'h00 || rdValid_o !== 1'b0) begin failures++; $display("FAIL reset_rdata got=%h/%b exp=00/0", rdata_o, rdValid_o); end
    checks++; if (overflw_o !== 1'b0 || underflw_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b/%b exp=0/0", overflw_o, underflw_o); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [7:0] d;
    logic       v;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 8'(i), 1'b0, d, v);
      if (i == 14) begin
        checks++; if (full_o !== 1'b0) begin failures++; $display("FAIL fill_full15 got=%b exp=0", full_o); end
      end
    end
    checks++; if (full_o !== 1'b1 || level_o !== 5'd16) begin failures++; $display("FAIL fill_full16 got=%b lvl=%0d exp=1 lvl=16", full_o, level_o); end
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 8'h00, 1'b1, d, v);
      checks++; if (d !== 8'(i) || v !== 1'b1) begin failures++; $display("FAIL drain_data[%0d] got=%h/%b exp=%h/1", i, d, v, 8'(i)); end
      if (i == 14) begin
        checks++; if (empty_o !== 1'b0) begin failures++; $display("FAIL drain_empty15 got=%b exp=0", empty_o); end
      end
    end
    checks++; if (empty_o !== 1'b1 || level_o !== 5'd0) begin failures++; $display("FAIL drain_empty16 got=%b lvl=%0d exp=1 lvl=0", empty_o, level_o); end
  endtask

  task automatic test_thresholds();
    logic [7:0] d;
    logic       v;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      xfer(1'b1, 8'(8'h30 + i), 1'b0, d, v);
      if (i == 10) begin
        checks++; if (almost_full_o !== 1'b0) begin failures++; $display("FAIL af_at11 got=%b exp=0", almost_full_o); end
      end
    end
    checks++; if (almost_full_o !== 1'b1 || level_o !== 5'd12) begin failures++; $display("FAIL af_at12 got=%b lvl=%0d exp=1 lvl=12", almost_full_o, level_o); end
    for (int i = 0; i < 10; i++) begin
      xfer(1'b0, 8'h00, 1'b1, d, v);
      if (i == 8) begin
        checks++; if (almost_empty_o !== 1'b0 || level_o !== 5'd3) begin failures++; $display("FAIL ae_at3 got=%b lvl=%0d exp=0 lvl=3", almost_empty_o, level_o); end
      end
    end
    checks++; if (almost_empty_o !== 1'b1 || level_o !== 5'd2) begin failures++; $display("FAIL ae_at2 got=%b lvl=%0d exp=1 lvl=2", almost_empty_o, level_o); end
    checks++; if (almost_full_o !== 1'b0) begin failures++; $display("FAIL af_cleared got=%b exp=0", almost_full_o); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic       v;
    do_reset();
    for (int i = 0; i < 16; i++) xfer(1'b1, 8'(8'h10 + i), 1'b0, d, v);
    xfer(1'b1, 8'hAA, 1'b0, d, v);
    checks++; if (overflw_o !== 1'b1 || level_o !== 5'd16) begin failures++; $display("FAIL ovf_pulse got=%b lvl=%0d exp=1 lvl=16", overflw_o, level_o); end
    tick();
    checks++; if (overflw_o !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", overflw_o); end
    xfer(1'b1, 8'hAA, 1'b1, d, v);
    checks++; if (d !== 8'h10 || level_o !== 5'd16 || overflw_o !== 1'b0) begin failures++; $display("FAIL ovf_rw got=%h lvl=%0d ovf=%b exp=10 lvl=16 ovf=0", d, level_o, overflw_o); end
    for (int i = 1; i < 16; i++) begin
      xfer(1'b0, 8'h00, 1'b1, d, v);
      checks++; if (d !== 8'(8'h10 + i)) begin failures++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, d, 8'(8'h10 + i)); end
    end
    xfer(1'b0, 8'h00, 1'b1, d, v);
    checks++; if (d !== 8'hAA || empty_o !== 1'b1) begin failures++; $display("FAIL ovf_last got=%h empty=%b exp=aa empty=1", d, empty_o); end
  endtask

  task automatic test_underflow();
    logic [7:0] d;
    logic       v;
    do_reset();
    xfer(1'b1, 8'h55, 1'b1, d, v);
    checks++; if (underflw_o !== 1'b1 || level_o !== 5'd1) begin failures++; $display("FAIL unf_pulse got=%b lvl=%0d exp=1 lvl=1", underflw_o, level_o); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (v !== 1'b0) begin failures++; $display("FAIL unf_no_valid got=%b exp=0", v); end
`endif
    tick();
    checks++; if (underflw_o !== 1'b0) begin failures++; $display("FAIL unf_one_cycle got=%b exp=0", underflw_o); end
    xfer(1'b0, 8'h00, 1'b1, d, v);
    checks++; if (d !== 8'h55 || v !== 1'b1 || level_o !== 5'd0) begin failures++; $display("FAIL unf_read got=%h/%b lvl=%0d exp=55/1 lvl=0", d, v, level_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] d, wd, exp_d;
    logic       v, wr, rd;
    int         nw = 0;
    int         nr = 0;
    int         bad = 0;
    do_reset();
    for (int cyc = 0; cyc < 1000 && (nw < 40 || nr < 40); cyc++) begin
      rd = (nr < 40) && (q.size() > 0) && ($urandom_range(0, 1) == 1);
      wr = (nw < 40) && ($urandom_range(0, 2) != 0);
      if (q.size() == 16 && !rd) wr = 1'b0;
      wd = 8'($urandom);
      xfer(wr, wd, rd, d, v);
      if (rd) begin
        exp_d = q.pop_front();
        nr++;
        checks++; if (d !== exp_d || v !== 1'b1) begin failures++; bad++; if (bad < 5) $display("FAIL b2b_data[%0d] got=%h/%b exp=%h/1", nr, d, v, exp_d); end
      end
      if (wr) begin
        q.push_back(wd);
        nw++;
      end
      checks++; if (level_o !== 5'(q.size())) begin failures++; bad++; if (bad < 5) $display("FAIL b2b_level got=%0d exp=%0d", level_o, q.size()); end
    end
    checks++; if (nw != 40 || nr != 40) begin failures++; $display("FAIL b2b_budget got=%0d/%0d exp=40/40", nw, nr); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic       v;
    do_reset();
    for (int i = 0; i < 7; i++) xfer(1'b1, 8'(8'h60 + i), 1'b0, d, v);
    checks++; if (level_o !== 5'd7) begin failures++; $display("FAIL mid_level7 got=%0d exp=7", level_o); end
    wrEn_i  = 1'b1;
    wdata_i = 8'h77;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    wrEn_i = 1'b0;
    checks++; if (level_o !== 5'd0 || empty_o !== 1'b1 || almost_empty_o !== 1'b1) begin failures++; $display("FAIL mid_empty got=lvl%0d %b/%b exp=lvl0 1/1", level_o, empty_o, almost_empty_o); end
    checks++; if (full_o !== 1'b0 || almost_full_o !== 1'b0 || rdata_o !== 8'h00 || rdValid_o !== 1'b0) begin failures++; $display("FAIL mid_outs got=%b/%b %h/%b exp=0/0 00/0", full_o, almost_full_o, rdata_o, rdValid_o); end
    checks++; if (overflw_o !== 1'b0 || underflw_o !== 1'b0) begin failures++; $display("FAIL mid_err got=%b/%b exp=0/0", overflw_o, underflw_o); end
    @(negedge clk) rst_n = 1'b1;
    xfer(1'b0, 8'h00, 1'b1, d, v);
    checks++; if (underflw_o !== 1'b1 || v !== 1'b0 || level_o !== 5'd0) begin failures++; $display("FAIL mid_unf got=%b/%b lvl=%0d exp=1/0 lvl=0", underflw_o, v, level_o); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of entries, power of two, >= 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per entry.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-4: almost-full level, legal range 1..DEPTH.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost-empty level, legal range 0..DEPTH-1.
REQ-005 SHALL have derived constant PTR_WIDTH = clog2(DEPTH), with level width PTR_WIDTH+1.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, ports as listed below.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 wrEn_i  input  1  write request.
REQ-010 wdata_i  input  DATA_WIDTH  write data.
REQ-011 rdEn_i  input  1  read (pop) request.
REQ-012 rdata_o  output  DATA_WIDTH  read data.
REQ-013 rdValid_o  output  1  rdata_o holds valid popped/head data.
REQ-014 full_o, empty_o  output  1 each  level==DEPTH / level==0.
REQ-015 almost_full_o, almost_empty_o  output  1 each  level>=AF_THRESH / level<=AE_THRESH.
REQ-016 level_o  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-017 overflw_o, underflw_o  output  1 each  one-cycle error pulses.

Function
REQ-018 A write SHALL be accepted when wrEn_i=1 and (full_o=0, or full_o=1 with a read accepted in the same cycle).
REQ-019 A read SHALL be accepted when rdEn_i=1 and empty_o=0; a read is never satisfied by same-cycle write data.
REQ-020 A rejected write SHALL leave state unchanged and pulse overflw_o high for exactly the next cycle.
REQ-021 A rejected read SHALL leave state unchanged and pulse underflw_o high for exactly the next cycle.
REQ-022 Level SHALL be a register: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 All flags SHALL be decoded from the level register; a change is visible one cycle after the accepting edge.
REQ-024 Write and read pointers SHALL wrap from DEPTH-1 to 0 with no gap and no lost entry.
REQ-025 Data SHALL be returned in strict write order.

Reset
REQ-026 On rst_n=0, asynchronously: pointers=0, level_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, rdata_o=0, rdValid_o=0, overflw_o=0, underflw_o=0.
REQ-027 Storage contents SHALL not be reset; entries present at reset SHALL be discarded and never read.
REQ-028 Reset assertion mid-transfer SHALL abort the transfer; the first request after deassertion SHALL be treated as on an empty FIFO.

Configuration
REQ-029 Macro SYNC_FIFO_FWFT_EN undefined: standard mode; rdata_o is registered, updated one cycle after an accepted read and held otherwise; rdValid_o pulses for that cycle.
REQ-030 Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; rdata_o presents the head entry whenever empty_o=0, rdValid_o = !empty_o, and rdEn_i pops the head.

Structure
REQ-031 Package fifo_pkg SHALL hold default DEPTH/DATA_WIDTH constants and the threshold legality checks.
REQ-032 Storage SHALL be sub-module fifo_ram: DEPTH x DATA_WIDTH, synchronous write, asynchronous read.
REQ-033 Illegal parameter values SHALL cause an elaboration-time error.

Verification (DEPTH=16, DATA_WIDTH=8, AF_THRESH=12, AE_THRESH=2)
REQ-034 Write 0x00..0x0F, then read 16 -> data 0x00..0x0F in order; full_o one cycle after 16th write; empty_o one cycle after 16th read.
REQ-035 Write 12 -> almost_full_o=1 and level_o=12; read 10 -> almost_empty_o=1 at level_o=2.
REQ-036 When full, wrEn_i alone with 0xAA -> overflw_o pulse, level_o stays 16; then rdEn_i+wrEn_i -> both accepted, level_o stays 16, 0xAA read last.
REQ-037 When empty, rdEn_i+wrEn_i with 0x55 -> underflw_o pulse, level_o=1, next read returns 0x55.
REQ-038 Run 40 writes/reads with interleaved random enables -> scoreboard match across pointer wraparound.
REQ-039 Assert rst_n=0 at level_o=7 -> all outputs at reset values immediately; next read -> underflw_o; repeat the run with SYNC_FIFO_FWFT_EN defined.
